ctrl_mem_datos: RTL and testbench

CTRL_MEM_DATOS -- requirements
Module: ctrl_mem_datos

---
 rtl/mem_datos_pkg.sv | 16 +
 rtl/ctrl_mem_datos.sv | 99 +++++++++
 tb/tb_ctrl_mem_datos.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_datos_pkg.sv
// mem_datos_pkg: shared types and constants for the data-memory controller.
// FSM state encoding, default memory depth, word-index width, counter width.
package mem_datos_pkg;

  localparam int MEM_WORDS = 120;
  localparam int ADDR_W    = 7;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_e;

endpackage

// File: rtl/ctrl_mem_datos.sv
// ctrl_mem_datos: single-outstanding LW/SW bridge from core to data memory.
// Optional macro CTRL_MEM_DATOS_ERR_EN enables misaligned/out-of-range checks.
module ctrl_mem_datos
  import mem_datos_pkg::*;
#(
  parameter int MEM_WORDS = mem_datos_pkg::MEM_WORDS,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_w,
  output logic              mem_r,
  input  logic [31:0]       mem_dout
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              addr_bad;

`ifdef CTRL_MEM_DATOS_ERR_EN
  assign addr_bad = (req_addr[1:0] != 2'b00) ||
                    ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
`else
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:9], req_addr[1:0]};
  assign addr_bad    = 1'b0;
`endif

  // Moore outputs decoded purely from the current state.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_w      = (state_q == WRITE);
  assign mem_r      = (state_q == READ);

  assign mem_addr   = addr_q;
  assign mem_din    = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Request FSM with inline read-latency down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[8:2];
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= addr_bad;
            cnt_q   <= LAT_INIT;
            if (addr_bad)    state_q <= RESP;
            else if (req_we) state_q <= WRITE;
            else             state_q <= READ;
          end
        end
        WRITE: begin
          state_q <= RESP;
        end
        READ: begin
          if (cnt_q == '0) begin
            rdata_q <= mem_dout;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_mem_datos.sv
// tb_ctrl_mem_datos: directed + scoreboarded random traffic, MEM_LAT=3.
// Expectations follow CTRL_MEM_DATOS_ERR_EN when it is defined.
module tb_ctrl_mem_datos;
  import mem_datos_pkg::*;

  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_w;
  logic              mem_r;
  logic [31:0]       mem_dout;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] rd;
    int          nw;
    int          nr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] exp_mem [16];
  logic [31:0] mem_arr [128];
  logic [31:0] rd;
  logic [31:0] v;
  logic        er;
  logic        to;
  logic        w;
  int          nw;
  int          nr;
  int          wi;
  int          exp_nr;
  int          exp_nw;
  logic        exp_err;

  always #5 clk = ~clk;

  ctrl_mem_datos #(
    .MEM_WORDS(120),
    .MEM_LAT  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_w     (mem_w),
    .mem_r     (mem_r),
    .mem_dout  (mem_dout)
  );

  // Memory model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_w) mem_arr[mem_addr] <= mem_din;
  end
  assign mem_dout = mem_arr[mem_addr];

  always @(negedge clk) begin
    compared++;
    assert (!(mem_w && mem_r)) else begin
      mismatched++;
      $error("FAIL mutex observed=%b%b expected=not-both", mem_w, mem_r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] ord, output logic oer,
                         output int onw, output int onr,
                         output logic oto);
    onw = 0;
    onr = 0;
    oto = 1'b1;
    ord = '0;
    oer = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin
        oto = 1'b0;
        break;
      end
      onw += int'(mem_w);
      onr += int'(mem_r);
      tick();
    end
    if (!oto) begin
      repeat (hold) tick();
      ord = resp_rdata;
      oer = resp_err;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem_arr[i] = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) tick();

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_strobes", {30'd0, mem_w, mem_r}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    rst = 1'b0;
    tick();

    // Store 0x10 <- DEADBEEF, cycle-accurate.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'hDEADBEEF;
    tick();
    req_valid = 1'b0;
    chk("st_n1_mem_w", 32'(mem_w), 32'd1);
    chk("st_n1_mem_r", 32'(mem_r), 32'd0);
    chk("st_n1_addr", 32'(mem_addr), 32'd4);
    chk("st_n1_din", mem_din, 32'hDEADBEEF);
    chk("st_n1_valid", 32'(resp_valid), 32'd0);
    chk("st_n1_ready", 32'(req_ready), 32'd0);
    tick();
    chk("st_n2_mem_w", 32'(mem_w), 32'd0);
    chk("st_n2_valid", 32'(resp_valid), 32'd1);
    chk("st_n2_rdata", resp_rdata, 32'd0);
    chk("st_n2_addr", 32'(mem_addr), 32'd4);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("st_n3_valid", 32'(resp_valid), 32'd0);
    chk("st_n3_ready", 32'(req_ready), 32'd1);

    // Load 0x10, three read-strobe cycles.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      chk($sformatf("ld_n%0d_mem_r", c), 32'(mem_r), 32'd1);
      chk($sformatf("ld_n%0d_mem_w", c), 32'(mem_w), 32'd0);
      chk($sformatf("ld_n%0d_valid", c), 32'(resp_valid), 32'd0);
      tick();
    end
    chk("ld_n4_mem_r", 32'(mem_r), 32'd0);
    chk("ld_n4_valid", 32'(resp_valid), 32'd1);
    chk("ld_n4_rdata", resp_rdata, 32'hDEADBEEF);

    // Backpressure with a competing request.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, 32'hDEADBEEF);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_mem_w", 32'(mem_w), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_rel_valid", 32'(resp_valid), 32'd0);
    chk("bp_rel_ready", 32'(req_ready), 32'd1);
    tick();
    chk("bp_no_accept", {30'd0, mem_w, req_ready}, 32'd1);

    // Word 120 load and misaligned store.
`ifdef CTRL_MEM_DATOS_ERR_EN
    exp_err = 1'b1;
    exp_nr  = 0;
    exp_nw  = 0;
`else
    exp_err = 1'b0;
    exp_nr  = LAT;
    exp_nw  = 1;
`endif
    run_req(1'b0, 32'h1E0, 32'h0, 0, rd, er, nw, nr, to);
    chk("oor_timeout", 32'(to), 32'd0);
    chk("oor_err", 32'(er), 32'(exp_err));
    chk("oor_nr", 32'(nr), 32'(exp_nr));
    chk("oor_nw", 32'(nw), 32'd0);
`ifndef CTRL_MEM_DATOS_ERR_EN
    chk("oor_mem_addr", 32'(mem_addr), 32'd120);
`endif
    run_req(1'b1, 32'h11, 32'hCAFEF00D, 1, rd, er, nw, nr, to);
    chk("mis_timeout", 32'(to), 32'd0);
    chk("mis_err", 32'(er), 32'(exp_err));
    chk("mis_nw", 32'(nw), 32'(exp_nw));
    chk("mis_nr", 32'(nr), 32'd0);
    chk("mis_rdata", rd, 32'd0);

    // Reset in the second read cycle.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    tick();
    req_valid = 1'b0;
    chk("rr_c1_mem_r", 32'(mem_r), 32'd1);
    tick();
    chk("rr_c2_mem_r", 32'(mem_r), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_mem_r", 32'(mem_r), 32'd0);
    chk("rr_valid", 32'(resp_valid), 32'd0);
    chk("rr_ready", 32'(req_ready), 32'd1);
    chk("rr_mem_addr", 32'(mem_addr), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rr_quiet", {30'd0, resp_valid, mem_r}, 32'd0);
    end

    // Scoreboarded traffic over words 0..15.
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      exp_mem[i] = v;
      e.rd = '0;
      e.nw = 1;
      e.nr = 0;
      sb_q.push_back(e);
      run_req(1'b1, 32'(i) << 2, v, 0, rd, er, nw, nr, to);
      e = sb_q.pop_front();
      chk("pre_timeout", 32'(to), 32'd0);
      chk("pre_nw", 32'(nw), 32'(e.nw));
    end
    for (int i = 0; i < 1000; i++) begin
      w  = 1'($urandom_range(0, 1));
      wi = int'($urandom_range(0, 15));
      v  = $urandom;
      if (w) begin
        exp_mem[wi] = v;
        e.rd = '0;
        e.nw = 1;
        e.nr = 0;
      end else begin
        e.rd = exp_mem[wi];
        e.nw = 0;
        e.nr = LAT;
      end
      sb_q.push_back(e);
      run_req(w, 32'(wi) << 2, v, int'($urandom_range(0, 2)),
              rd, er, nw, nr, to);
      e = sb_q.pop_front();
      chk("rnd_timeout", 32'(to), 32'd0);
      chk("rnd_rdata", rd, e.rd);
      chk("rnd_err", 32'(er), 32'd0);
      chk("rnd_strobes", 32'(nw * 16 + nr), 32'(e.nw * 16 + e.nr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
